// File: rtl/pulse_handshake_tx.sv
// Source side of a pulse-to-handshake crossing: queues local event strobes and delivers each one
// to an unrelated clock domain as a complete four-phase req/ack exchange.
module pulse_handshake_tx #(
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             event_in,
  input  logic             ack_async,
  input  logic             ovf_clr,
  output logic             req,
  output logic             busy,
  output logic             sent,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] PendMax  = '1;
  localparam logic [CNT_W-1:0] PendZero = '0;
  localparam logic [CNT_W-1:0] PendOne  = CNT_W'(1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRel  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic                   sent_q, sent_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

  logic ack_s;
  logic launch;
  logic ovf_set;

  // ack_async is sampled only by the first synchronizer stage.
  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_async};
  assign ack_s      = ack_sync_q[SYNC_STAGES-1];

  // A stale ack still high from a previous exchange holds off the next launch.
  assign launch = (state_q == StIdle) && (pending_q != PendZero) && !ack_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= ack_sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sent_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_d = 1'b0;
        if (launch) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        req_d = 1'b1;
        if (ack_s) begin
          state_d = StRel;
          req_d   = 1'b0;
          sent_d  = 1'b1;
        end
      end
      StRel: begin
        req_d = 1'b0;
        if (!ack_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // An event and a launch on the same edge cancel, which also covers a full counter.
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    unique case ({event_in, launch})
      2'b10: begin
        if (pending_q == PendMax) begin
          ovf_set = 1'b1;
        end else begin
          pending_d = pending_q + PendOne;
        end
      end
      2'b01:   pending_d = pending_q - PendOne;
      default: pending_d = pending_q;
    endcase
  end

  // A new drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      sent_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sent_q     <= sent_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign req      = req_q;
  assign sent     = sent_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle) || (pending_q != PendZero);

endmodule

// File: doc/pulse_handshake_tx.md
Name: pulse_handshake_tx

Overview:
- Source-side partner of the edge-trap synchronizer.
- Takes single-cycle event pulses in the local clk domain and queues them in a saturating pending counter.
- Delivers each event across a clock-domain boundary as one full four-phase req/ack handshake. The far domain synchronizes req; this block synchronizes the returning ack internally.
- Sits wherever a fast-domain controller must hand discrete events (e.g. "keystream byte ready") to a slower or unrelated domain without losing any.

Parameters:
- CNT_W, 4, width of the pending-event counter; max queued events = 2^CNT_W-1.
- SYNC_STAGES, 2, number of flip-flops in the ack synchronizer chain (legal: 2..4).

Ports:
- clk  input  1  local clock; all state is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all state immediately.
- event_in  input  1  single-cycle event strobe; each high cycle is one event.
- ack_async  input  1  acknowledge level from far domain; asynchronous to clk.
- ovf_clr  input  1  synchronous clear of the overflow flag.
- req  output  1  request level to far domain; driven directly from a flop, glitch-free.
- busy  output  1  high whenever state != IDLE or pending != 0.
- sent  output  1  one-cycle pulse when an event's ack is received.
- pending  output  CNT_W  number of events queued but not yet launched.
- overflow  output  1  sticky; set when an event was dropped.

Behaviour:
- Reset (reset_n=0, async) applies immediately, including mid-handshake:
  - req=0, busy=0, sent=0, pending=0, overflow=0.
  - State IDLE; all ack synchronizer flops cleared to 0.
- Ack synchronizer: ack_async passes through SYNC_STAGES flops to give ack_s. No other logic may sample ack_async.
- FSM states are IDLE, REQ and REL:
  - IDLE: if pending!=0 and ack_s==0, then at the next edge go to REQ, set req=1 and decrement pending (launch). If ack_s==1 (stale ack), stay in IDLE and do not launch.
  - REQ: req held at 1. When ack_s==1, at the next edge go to REL, set req=0 and pulse sent=1 for that one cycle.
  - REL: req=0. When ack_s==0, at the next edge go to IDLE.
- Pending counter update per edge:
  - The net change is +1 if event_in is high and -1 if a launch occurs.
  - A simultaneous event and launch leaves pending unchanged.
  - Saturation: if pending==2^CNT_W-1, event_in=1 and no launch, then pending is unchanged and overflow is set to 1.
  - An event arriving while pending is at max in the same cycle as a launch is accepted (net 0), with no overflow.
- Overflow flag:
  - overflow clears on ovf_clr=1.
  - If ovf_clr and a new overflow condition occur in the same cycle, set wins (overflow=1).
- Latency:
  - event_in high at edge k with pending=0, IDLE and ack_s=0 gives pending=1 after edge k and req=1 after edge k+1.
  - Minimum handshake period from req rise to the next possible req rise is 2*SYNC_STAGES+3 clk cycles, given an instant far-side ack.
- busy is combinational from state and pending only.
- Far-domain ack behaviour that violates the protocol is tolerated without deadlock:
  - ack dropping while in REQ keeps the block in REQ.
  - ack rising in IDLE blocks launches until it falls.

Test Plan:
- Single event: reset, event_in one cycle, far model acks 3 cycles after seeing req → pending 0→1→0, req=1 one edge after pending=1, sent pulses once, busy returns 0, exactly 1 handshake.
- Burst: CNT_W=4, 5 back-to-back event_in cycles while first handshake in flight → pending peaks at 4, exactly 5 req rising edges total, 5 sent pulses, overflow=0.
- Saturation: hold ack_async=1 pre-reset-release (stale ack), pulse 16 events → pending=15, overflow=1 on the 16th. Drop ack → 15 handshakes complete. ovf_clr → overflow=0.
- Simultaneous: event_in high on the same edge as a launch with pending=1 → pending stays 1; with pending=15 → stays 15, overflow stays 0.
- Reset mid-handshake: assert reset_n=0 while in REQ with pending=3 → req, pending and busy go to 0 immediately without waiting for a clk edge. After release with ack_async=0, no req rises until a new event.
- Sync depth: SYNC_STAGES=3, ack_async rises → sent asserted exactly 4 edges later (3 sync edges + 1 FSM edge), req low at the same edge.
